seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
- Multi-cycle signed integer divider. It is the inverse operation of the team's sequential Booth multiplier and uses the same start-pulse handshake.
- Accepts a two's-complement dividend and divisor on a one-cycle `start`. Performs one restoring-division iteration per clock on operand magnitudes, then applies sign correction.
- Registers the quotient and remainder and pulses `done`.
- Sits beside the multiplier in the lab arithmetic datapath.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (two's complement).

Ports:
- clk      input   1      rising-edge clock, single clock domain
- rst_n    input   1      reset, synchronous and active-low
- start    input   1      request; sampled only in IDLE
- a        input   WIDTH  signed dividend, sampled on the accepting edge
- b        input   WIDTH  signed divisor, sampled on the accepting edge
- q        output  WIDTH  signed quotient, registered
- r        output  WIDTH  signed remainder, registered
- done     output  1      one-cycle pulse: q, r and dz are valid
- busy     output  1      high from the accepting edge until the edge that raises done
- dz       output  1      divide-by-zero flag for the current result, registered

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; q=0, r=0, done=0, busy=0, dz=0.
  - All internal registers (magnitudes, partial remainder, counter, sign bits) are cleared.
  - Reset mid-operation aborts the division: no done, and no partial result reaches q or r.
- States: IDLE, CAL, FIN.
- IDLE:
  - start=1 at edge E0 (accepting edge):
    - latch |a| and |b| as WIDTH+1-bit unsigned values;
    - latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB];
    - latch dz = (b==0);
    - clear the partial remainder and the counter;
    - set busy=1; go to CAL.
  - start=0: stay in IDLE; q, r and dz hold their last values.
- CAL (edges E1..E_WIDTH), one restoring step per edge:
  - shift {rem, dividend} left by 1;
  - trial = rem − |b|;
  - if trial ≥ 0: rem = trial and quotient LSB = 1; else quotient LSB = 0.
  - The counter increments each edge. The edge on which counter = WIDTH−1 moves the state to FIN.
- FIN (edge E_WIDTH+1):
  - q = sign_q ? −qmag : qmag, truncated to WIDTH bits;
  - r = sign_r ? −rem : rem, truncated to WIDTH bits;
  - done=1 for exactly the following cycle; busy=0; go to IDLE.
- Fixed latency: done is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 edges after the accepting edge. Latency is independent of the operand values.
- Rounding rule: the quotient truncates toward zero; the remainder takes the sign of the dividend; a = q*b + r.
- Divide by zero: the block runs the full latency. The result is forced to q = all ones (−1), r = a, dz=1.
- Overflow: most-negative / −1 wraps, giving q = most-negative and r = 0. dz=0; no flag is raised.
- start while busy: ignored and not queued.
- start back-to-back: start=1 in the done cycle is sampled in IDLE and accepted. Throughput is one result per WIDTH+2 cycles.
- Operand stability: a and b may change after the accepting edge without affecting the result.
- Width rules: magnitudes are WIDTH+1 bits, so |most-negative| is representable. The partial remainder is WIDTH+1 bits.

Decomposition:
- Shared package (arith_pkg):
  - state encoding constants IDLE=2'b00, CAL=2'b01, FIN=2'b10;
  - default WIDTH constant;
  - a magnitude/negate helper function, shared with the multiplier.
- One natural sub-module: div_restore_step. It is combinational and WIDTH-parameterised: (rem, dividend bit, divisor) -> (next rem, quotient bit). It is instantiated once in CAL.

Test Plan:
- Reset then idle: rst_n=0 for 2 edges, start=0 -> q=0, r=0, done=0, busy=0, dz=0 throughout.
- Sign cases (WIDTH=4), each with done exactly 5 edges after the accepting edge:
  - 7/2 -> q=3, r=1
  - −7/2 -> q=−3, r=−1
  - 7/−2 -> q=−3, r=1
  - −7/−2 -> q=3, r=−1
- Boundary operands:
  - −8/3 -> q=−2, r=−2
  - −8/−1 -> q=−8 (4'b1000), r=0, dz=0
  - 0/5 -> q=0, r=0
- Divide by zero: 5/0 -> q=4'b1111, r=5, dz=1, same latency. The next division 6/3 -> q=2, r=0, dz=0.
- Handshake:
  - start held high for 3 cycles during busy -> exactly one result;
  - start asserted in the done cycle -> second result 6 edges after the first done;
  - a and b changed after acceptance -> result unaffected.
- Reset mid-operation: rst_n=0 at edge E2 of 7/2 -> no done pulse, q=0 and r=0. A new 6/4 after release gives q=1, r=2.

Source files
------------

// File: rtl/seq_signed_divider_pkg.sv
// Shared arithmetic definitions for the lab datapath: FSM encoding, default width
// and the two's-complement magnitude helper also used by the Booth multiplier.
package seq_signed_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CAL  = 2'b01,
        FIN  = 2'b10
    } state_t;

    // Callers sign-extend into MAX_WIDTH bits and size-cast the result back down.
    function automatic logic [MAX_WIDTH-1:0] magnitude(input logic [MAX_WIDTH-1:0] val);
        return val[MAX_WIDTH-1] ? (~val + MAX_WIDTH'(1)) : val;
    endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start-pulse handshake and result bus shared by the sequential divider and multiplier.
interface seq_signed_divider_if
    import seq_signed_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             done;
    logic             busy;
    logic             dz;

    modport master (output start, a, b, input q, r, done, busy, dz);
    modport slave  (input start, a, b, output q, r, done, busy, dz);
endinterface

// File: rtl/seq_signed_divider_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_restore_step
    import seq_signed_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] i_rem,
    input  logic           i_bit,
    input  logic [WIDTH:0] i_dvs,
    output logic [WIDTH:0] o_rem,
    output logic           o_qBit
);
    logic [WIDTH+1:0] w_trial;

    // One extra bit on the trial subtraction exposes the borrow as the sign.
    assign w_trial = {i_rem, i_bit} - {1'b0, i_dvs};
    assign o_qBit  = ~w_trial[WIDTH+1];
    assign o_rem   = o_qBit ? w_trial[WIDTH:0] : {i_rem[WIDTH-1:0], i_bit};
endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes, then sign correction.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_signed_divider_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH:0]   r_dvs;
    logic [WIDTH:0]   r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_signQ;
    logic             r_signR;
    logic             r_dzPend;
    logic [WIDTH-1:0] r_aRaw;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_done;
    logic             r_busy;
    logic             r_dz;

    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH:0]   w_bMag;
    logic [WIDTH:0]   w_nextRem;
    logic             w_qBit;

    // |most-negative| still fits: WIDTH bits unsigned for the dividend, WIDTH+1 for the divisor.
    assign w_aMag = WIDTH'(magnitude(MAX_WIDTH'(signed'(bus.a))));
    assign w_bMag = (WIDTH+1)'(magnitude(MAX_WIDTH'(signed'(bus.b))));

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_nextRem),
        .o_qBit (w_qBit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_signQ  <= 1'b0;
            r_signR  <= 1'b0;
            r_dzPend <= 1'b0;
            r_aRaw   <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dvd    <= w_aMag;
                        r_dvs    <= w_bMag;
                        r_signQ  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_signR  <= bus.a[WIDTH-1];
                        r_dzPend <= (bus.b == '0);
                        r_aRaw   <= bus.a;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CAL;
                    end
                end
                CAL: begin
                    // Quotient bits shift into the vacated dividend positions.
                    r_rem <= w_nextRem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qBit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    if (r_dzPend) begin
                        r_q <= '1;
                        r_r <= r_aRaw;
                    end else begin
                        r_q <= r_signQ ? -r_dvd : r_dvd;
                        r_r <= r_signR ? WIDTH'(-r_rem) : WIDTH'(r_rem);
                    end
                    r_dz    <= r_dzPend;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.done = r_done;
    assign bus.busy = r_busy;
    assign bus.dz   = r_dz;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench: an arithmetic reference model compared every cycle, plus directed literal checks.
module tb_seq_signed_divider;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nErrors = 0;

    seq_signed_divider_if #(.WIDTH(W)) bus();

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: operands captured when idle, result due W+1 edges later.
    bit                  mBusy = 1'b0;
    int                  mCnt  = 0;
    logic signed [W-1:0] mA = '0;
    logic signed [W-1:0] mB = '0;
    logic                mDone = 1'b0;
    logic                mDz   = 1'b0;
    logic [W-1:0]        mQ    = '0;
    logic [W-1:0]        mR    = '0;
    int                  sa;
    int                  sb;

    always @(posedge clk) begin
        if (!rst_n) begin
            mBusy = 1'b0;
            mCnt  = 0;
            mDone = 1'b0;
            mDz   = 1'b0;
            mQ    = '0;
            mR    = '0;
        end else begin
            mDone = 1'b0;
            if (mBusy) begin
                mCnt++;
                if (mCnt == W + 1) begin
                    sa = int'(mA);
                    sb = int'(mB);
                    if (sb == 0) begin
                        mQ  = '1;
                        mR  = mA;
                        mDz = 1'b1;
                    end else begin
                        mQ  = W'(sa / sb);
                        mR  = W'(sa % sb);
                        mDz = 1'b0;
                    end
                    mDone = 1'b1;
                    mBusy = 1'b0;
                end
            end else if (bus.start) begin
                mBusy = 1'b1;
                mCnt  = 0;
                mA    = bus.a;
                mB    = bus.b;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("model_done", bus.done, mDone);
            checkOutput("model_busy", bus.busy, mBusy);
            checkOutput("model_q", bus.q, mQ);
            checkOutput("model_r", bus.r, mR);
            checkOutput("model_dz", bus.dz, mDz);
        end
    end

    // Presents operands and start for the next edge, then scrambles the operands.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    task automatic waitDone(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic dz, output int edges);
        bit seen = 1'b0;
        edges = 0;
        while (edges < 20 && !seen) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checkOutput({tag, "_latency"}, seen ? edges : -1, W + 1);
        if (seen) begin
            checkOutput({tag, "_q"}, bus.q, q);
            checkOutput({tag, "_r"}, bus.r, r);
            checkOutput({tag, "_dz"}, bus.dz, dz);
        end
    endtask

    task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                          input logic [W-1:0] r, input logic dz, input string tag);
        int edges;
        @(negedge clk);
        applyStimulus(a, b);
        waitDone(tag, q, r, dz, edges);
    endtask

    initial begin
        int edges;
        int doneCount;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_q", bus.q, 0);
        checkOutput("reset_r", bus.r, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_dz", bus.dz, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", bus.busy, 0);

        runDiv(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, "p7_p2");
        runDiv(4'h9, 4'd2, 4'hD, 4'hF, 1'b0, "n7_p2");
        runDiv(4'd7, 4'hE, 4'hD, 4'd1, 1'b0, "p7_n2");
        runDiv(4'h9, 4'hE, 4'd3, 4'hF, 1'b0, "n7_n2");
        runDiv(4'h8, 4'd3, 4'hE, 4'hE, 1'b0, "n8_p3");
        runDiv(4'h8, 4'hF, 4'h8, 4'd0, 1'b0, "n8_n1");
        runDiv(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, "z_p5");
        runDiv(4'd5, 4'd0, 4'hF, 4'd5, 1'b1, "divzero");
        runDiv(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, "after_dz");

        // start held through the busy window must yield a single result
        @(negedge clk);
        bus.a     = 4'd3;
        bus.b     = 4'd1;
        bus.start = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        bus.start = 1'b0;
        doneCount = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                doneCount++;
                checkOutput("held_q", bus.q, 3);
            end
        end
        checkOutput("held_done_count", doneCount, 1);

        runDiv(4'd7, 4'd3, 4'd2, 4'd1, 1'b0, "b2b_first");
        applyStimulus(4'hB, 4'd2);
        waitDone("b2b_second", 4'hE, 4'hF, 1'b0, edges);
        checkOutput("b2b_gap", edges + 1, 6);

        // reset arrives on the second edge of an operation
        @(negedge clk);
        applyStimulus(4'd7, 4'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        doneCount = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
        end
        checkOutput("abort_done_count", doneCount, 0);
        checkOutput("abort_q", bus.q, 0);
        checkOutput("abort_r", bus.r, 0);
        runDiv(4'd6, 4'd4, 4'd1, 4'd2, 1'b0, "after_abort");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end
endmodule
